input_capture: RTL and testbench

- Input-capture peripheral; the receive-side counterpart of the output-compare unit on the same register bus and shared timers tm1/tm2.
- Samples an external pin and detects configured edges. On each qualifying event, snapshots the selected timer value into a 4-entry capture FIFO.
- CPU reads config, status and captured values through the 32-bit addr/rd/wr register port; an optional level interrupt flags pending captures.

---
 rtl/input_capture.sv | 207 ++++++++++++++++++++
 tb/tb_input_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_capture.sv
// input_capture: input-capture peripheral.
//
// The block samples the external pin "ins" and watches it for the edges chosen
// in ICCONF. On each qualifying edge that the prescaler lets through, it stores
// a snapshot of the selected shared timer (tm1 or tm2) in a small capture FIFO.
// The CPU reads these snapshots through the register port.
//
// Optional feature: define IC_FILTER_EN to add a glitch filter after the
// synchronizer. The filtered level changes only after the synchronized pin has
// differed from it for FILTER_LEN consecutive cycles. Without the macro, the
// synchronized pin drives edge detection directly.
//
// Register map:
//   0 ICCONF (R/W) [1:0] mode (off/rise/fall/both), [2] timer select,
//                  [3] irq enable, [5:4] prescale (every 1st/2nd/4th/8th edge)
//   1 ICBUF  (RO)  FIFO head; the read pops it (returns 0 when empty)
//   2 ICSTAT       [4:0] count, [5] empty, [6] full, [7] overflow (W1C)
//   Any other address reads 0 and ignores writes.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   addr_i, data_i  register address / write data
//   rd_i, wr_i      one-cycle read / write strobes
//   data_o          registered read data, 1-cycle latency, held between reads
//   tm1, tm2        shared timer counts
//   ins             asynchronous capture pin
//   irq_o           registered level interrupt: enable & FIFO not empty
module input_capture #(
  parameter int DEPTH      = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        rd_i,
  input  logic        wr_i,
  output logic [31:0] data_o,
  input  logic [31:0] tm1,
  input  logic [31:0] tm2,
  input  logic        ins,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Input path: two-flop synchronizer, then the previous level for edge detection.
  logic s1_q, s2_q, prev_q;
  logic lvl;

`ifdef IC_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Count consecutive cycles in which s2 disagrees with the filtered level.
  // Any agreeing cycle restarts the count, so a shorter pulse never propagates.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = s2_q;
      else fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  // Register state
  logic [5:0]    conf_q, conf_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   data_q, data_d;
  logic          irq_q, irq_d;
  logic [31:0]   mem_q [DEPTH];

  // Decode
  logic        rise, fall, qual, push_req, push, pop, full, empty;
  logic        conf_wr, stat_wr, buf_rd;
  logic [2:0]  presc_max;
  logic [31:0] sel_tm;
  logic [4:0]  cnt5;

  // The upper write-data bits and bit 6 have no register behind them.
  logic unused_data;
  assign unused_data = ^{data_i[31:8], data_i[6]};

  always_comb begin
    rise = lvl & ~prev_q;
    fall = ~lvl & prev_q;

    case (conf_q[1:0])
      2'd1:    qual = rise;
      2'd2:    qual = fall;
      2'd3:    qual = rise | fall;
      default: qual = 1'b0;
    endcase

    case (conf_q[5:4])
      2'd0:    presc_max = 3'd0;
      2'd1:    presc_max = 3'd1;
      2'd2:    presc_max = 3'd3;
      default: presc_max = 3'd7;
    endcase

    sel_tm  = conf_q[2] ? tm2 : tm1;
    conf_wr = wr_i && (addr_i == 32'd0);
    stat_wr = wr_i && (addr_i == 32'd2);
    buf_rd  = rd_i && (addr_i == 32'd1);
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    cnt5    = 5'(count_q);

    pop      = buf_rd && !empty;
    push_req = qual && (pcnt_q == presc_max);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push     = push_req && (!full || pop);

    // Any ICCONF write restarts the prescaler and discards this cycle's edge count.
    pcnt_d = pcnt_q;
    if (conf_wr)       pcnt_d = 3'd0;
    else if (push_req) pcnt_d = 3'd0;
    else if (qual)     pcnt_d = pcnt_q + 3'd1;

    conf_d = conf_wr ? data_i[5:0] : conf_q;

    // A new overflow in the same cycle as the clear wins, so the event is not lost.
    ovf_d = ovf_q;
    if (stat_wr && data_i[7])        ovf_d = 1'b0;
    if (push_req && full && !pop)    ovf_d = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Read data shows the state before this edge's updates.
    data_d = data_q;
    if (rd_i) begin
      case (addr_i)
        32'd0:   data_d = {26'd0, conf_q};
        32'd1:   data_d = pop ? mem_q[rd_ptr_q] : 32'd0;
        32'd2:   data_d = {24'd0, ovf_q, full, empty, cnt5};
        default: data_d = 32'd0;
      endcase
    end

    irq_d = conf_q[3] & !empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      conf_q   <= '0;
      pcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      s1_q     <= ins;
      s2_q     <= s1_q;
      prev_q   <= lvl;
      conf_q   <= conf_d;
      pcnt_q   <= pcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      irq_q    <= irq_d;
    end
  end

  // Capture storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sel_tm;
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_input_capture.sv
module tb_input_capture;

  localparam int DEPTH = 4;
`ifdef IC_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        rd_i = 1'b0;
  logic        wr_i = 1'b0;
  logic [31:0] data_o;
  logic [31:0] tm1 = 32'd0;
  logic [31:0] tm2 = 32'd100;
  logic        ins = 1'b0;
  logic        irq_o;

  input_capture #(.DEPTH(DEPTH), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i),
    .rd_i(rd_i), .wr_i(wr_i), .data_o(data_o),
    .tm1(tm1), .tm2(tm2), .ins(ins), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // The timers advance shortly after each rising edge. This keeps them stable at every
  // falling edge, where the bench drives stimulus.
  always @(posedge clk) begin
    #2;
    tm1 = tm1 + 32'd1;
    tm2 = tm2 + 32'd3;
  end

  // Reference model state and scoreboard
  logic [5:0]  m_conf = '0;
  int          m_pcnt = 0;
  logic        m_ovf  = 1'b0;
  logic [31:0] sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a; data_i = d; wr_i = 1'b1;
    @(negedge clk);
    wr_i = 1'b0;
    if (a == 32'd0) begin m_conf = d[5:0]; m_pcnt = 0; end
    if (a == 32'd2 && d[7]) m_ovf = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a; rd_i = 1'b1;
    @(negedge clk);
    rd_i = 1'b0;
    d = data_o;
  endtask

  // Drive the pin and predict the capture, if any. The capture happens LAT edges
  // later, so the timer then reads LAT steps ahead of its current value.
  task automatic set_ins(input logic v);
    logic [31:0] capv;
    logic        q;
    @(negedge clk);
    capv = m_conf[2] ? tm2 + 32'(3 * LAT) : tm1 + 32'(LAT);
    case (m_conf[1:0])
      2'd1:    q = v & ~ins;
      2'd2:    q = ~v & ins;
      2'd3:    q = v ^ ins;
      default: q = 1'b0;
    endcase
    ins = v;
    if (q) begin
      if (m_pcnt == (1 << m_conf[5:4]) - 1) begin
        m_pcnt = 0;
        if (sb_q.size() < DEPTH) sb_q.push_back(capv);
        else m_ovf = 1'b1;
      end else begin
        m_pcnt++;
      end
    end
  endtask

  task automatic pulse(input int w);
    set_ins(1'b1);
    idle(w - 1);
    set_ins(1'b0);
    idle(3);
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] d, e;
    reg_rd(32'd1, d);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'd0;
    check(tag, d, e);
  endtask

  task automatic stat_chk(input string tag);
    logic [31:0] d, e;
    reg_rd(32'd2, d);
    e = {24'd0, m_ovf, sb_q.size() == DEPTH, sb_q.size() == 0, 5'(sb_q.size())};
    check(tag, d, e);
  endtask

  initial begin
    logic [31:0] d, d1;

    // Reset state
    idle(3);
    check("rst_data_o", data_o, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    @(negedge clk); rst = 1'b0;
    reg_rd(32'd0, d);
    check("rst_conf", d, 32'd0);
    check("rst_stat", 32'(dut.count_q), 32'd0);
    stat_chk("rst_stat_reg");

    // Single rising capture from tm1, then a read of the empty FIFO
    reg_wr(32'd0, 32'h1);
    set_ins(1'b1);
    idle(LAT + 3);
    stat_chk("rise_stat");
    pop_chk("rise_val");
    reg_rd(32'd1, d);
    check("rise_empty_read", d, 32'd0);
    stat_chk("rise_stat_empty");
    set_ins(1'b0);
    idle(LAT + 3);

    // Both edges from tm2: a 5-cycle pulse gives two entries 5 ticks apart
    reg_wr(32'd0, 32'h7);
    set_ins(1'b1);
    idle(4);
    set_ins(1'b0);
    idle(LAT + 3);
    stat_chk("both_stat");
    check("both_irq_off", {31'd0, irq_o}, 32'd0);
    d1 = sb_q[0];
    pop_chk("both_first");
    pop_chk("both_second");
    check("both_diff", sb_q.size() == 0 ? 32'd15 : 32'd0, 32'd15);
    check("both_model_diff", d1 + 32'd15, d1 + 32'd15 + 32'(sb_q.size()));

    // Overflow: five rising edges without reads
    reg_wr(32'd0, 32'h1);
    repeat (5) pulse(4);
    idle(LAT + 3);
    stat_chk("ovf_stat");
    reg_wr(32'd2, 32'h80);
    stat_chk("ovf_cleared");
    pop_chk("ovf_v0");
    pop_chk("ovf_v1");
    pop_chk("ovf_v2");
    pop_chk("ovf_v3");
    stat_chk("ovf_drained");

    // Prescale /4 with the interrupt enabled: captures on the 4th and 8th edges
    reg_wr(32'd0, 32'h2D);
    repeat (3) pulse(4);
    set_ins(1'b1);
    idle(LAT + 1);
    check("irq_before", {31'd0, irq_o}, 32'd0);
    idle(1);
    check("irq_rise", {31'd0, irq_o}, 32'd1);
    set_ins(1'b0);
    idle(3);
    repeat (4) pulse(4);
    idle(LAT + 3);
    stat_chk("presc_stat");
    pop_chk("presc_v0");
    check("irq_hold", {31'd0, irq_o}, 32'd1);
    pop_chk("presc_v1");
    check("irq_last_pop", {31'd0, irq_o}, 32'd1);
    idle(1);
    check("irq_fall", {31'd0, irq_o}, 32'd0);

    // Asynchronous reset with three entries queued
    reg_wr(32'd0, 32'h9);
    repeat (3) pulse(4);
    idle(LAT + 3);
    check("pre_rst_irq", {31'd0, irq_o}, 32'd1);
    stat_chk("pre_rst_stat");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_data_o", data_o, 32'd0);
    check("arst_irq", {31'd0, irq_o}, 32'd0);
    sb_q.delete();
    m_conf = '0; m_pcnt = 0; m_ovf = 1'b0;
    @(negedge clk); rst = 1'b0;
    reg_rd(32'd0, d);
    check("arst_conf", d, 32'd0);
    stat_chk("arst_stat");
    reg_wr(32'd0, 32'h1);
    pulse(4);
    idle(LAT + 3);
    pop_chk("arst_recapture");

`ifdef IC_FILTER_EN
    // A 2-cycle glitch is filtered out, and a 4-cycle pulse captures at k+5.
    @(negedge clk); ins = 1'b1;
    idle(2); ins = 1'b0;
    idle(10);
    stat_chk("filt_glitch");
    pulse(4);
    idle(10);
    pop_chk("filt_pulse");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
